// File: rtl/dispatch_pkg.sv
// Shared types and constants for the instruction fetch/dispatch stage.
// Also supplies a fallback for the IMEM_ADDR_WIDTH macro when the build does not define it.
`ifndef IMEM_ADDR_WIDTH
`define IMEM_ADDR_WIDTH 10
`endif

package dispatch_pkg;

    localparam int INST_WIDTH = 32;

    // Bit of an instruction word that selects its consumer (MSB).
    localparam int TGT_BIT = INST_WIDTH - 1;

    typedef enum logic {
        TGT_PE  = 1'b0,
        TGT_BUF = 1'b1
    } dispatch_target_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dispatch_state_e;

endpackage

// File: rtl/inst_dispatch_if.sv
// Instruction memory read port plus the PE and buffer instruction channels.
// The master side is the dispatcher; the slave side is the memory and the consumers.
interface inst_dispatch_if #(
    parameter int INST_WIDTH = dispatch_pkg::INST_WIDTH,
    parameter int ADDR_W     = `IMEM_ADDR_WIDTH
);
    logic                  imem_rd_en;
    logic [ADDR_W-1:0]     imem_addr;
    logic [INST_WIDTH-1:0] imem_rd_data;

    logic                  pe_inst_valid;
    logic                  pe_inst_ready;
    logic [INST_WIDTH-1:0] pe_inst;

    logic                  buf_inst_valid;
    logic                  buf_inst_ready;
    logic [INST_WIDTH-1:0] buf_inst;

    modport master (
        output imem_rd_en, imem_addr,
        input  imem_rd_data,
        output pe_inst_valid, pe_inst,
        input  pe_inst_ready,
        output buf_inst_valid, buf_inst,
        input  buf_inst_ready
    );

    modport slave (
        input  imem_rd_en, imem_addr,
        output imem_rd_data,
        input  pe_inst_valid, pe_inst,
        output pe_inst_ready,
        input  buf_inst_valid, buf_inst,
        output buf_inst_ready
    );
endinterface

// File: rtl/inst_queue.sv
// Synchronous prefetch FIFO. Push and pop may coincide at any occupancy.
// The head reads as zero while the queue is empty; storage itself is not reset.
module inst_queue #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;

    assign w_do_pop = i_pop && (r_count != '0);
    assign o_count  = r_count;
    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_head   = o_empty ? '0 : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; data only, so no reset.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end
endmodule

// File: rtl/inst_dispatch.sv
// In-order instruction fetch and dispatch: walks the program counter over a
// synchronous-read memory, buffers words in a prefetch queue and hands each
// word to the PE or buffer channel according to its MSB.
// Optional feature macro: INST_DISPATCH_PERF_EN adds saturating stall counters.
module inst_dispatch #(
    parameter int INST_WIDTH      = dispatch_pkg::INST_WIDTH,
    parameter int IMEM_ADDR_WIDTH = `IMEM_ADDR_WIDTH,
    parameter int QUEUE_DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [IMEM_ADDR_WIDTH-1:0] instruction_count,
    inst_dispatch_if.master            bus,
    output logic [IMEM_ADDR_WIDTH-1:0] program_counter,
    output logic                       busy,
    output logic                       done
`ifdef INST_DISPATCH_PERF_EN
    ,
    output logic [31:0]                pe_stall_cycles,
    output logic [31:0]                buf_stall_cycles
`endif
);
    import dispatch_pkg::*;

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    dispatch_state_e            r_state;
    dispatch_state_e            w_state_nxt;
    logic [IMEM_ADDR_WIDTH-1:0] r_pc;
    logic [IMEM_ADDR_WIDTH-1:0] r_count;
    logic                       r_inflight;

    logic                       w_rd_en;
    logic                       w_busy;
    logic                       w_done;
    logic                       w_last_issue;
    logic                       w_credit_ok;
    logic [CNT_W:0]             w_outstanding;
    logic                       w_start_acc;

    logic                       w_push;
    logic                       w_pop;
    logic [INST_WIDTH-1:0]      w_head;
    logic [CNT_W-1:0]           w_q_count;
    logic                       w_q_empty;
    logic                       w_q_full;
    dispatch_target_e           w_head_tgt;
    logic                       w_pe_valid;
    logic                       w_buf_valid;

    // Credit counts queued entries plus the read still in flight, so a word
    // returning from memory always has a slot waiting for it.
    assign w_outstanding = {1'b0, w_q_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_credit_ok   = (w_outstanding < (CNT_W+1)'(QUEUE_DEPTH));
    assign w_last_issue  = (r_pc == r_count - IMEM_ADDR_WIDTH'(1));
    assign w_start_acc   = (r_state == IDLE) && start;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; DRAIN finishes on the edge that empties the queue.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (instruction_count == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (w_rd_en && w_last_issue) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!r_inflight && (w_q_empty || (w_q_count == CNT_W'(1) && w_pop))) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs: read strobe, busy and done.
    always_comb begin
        w_rd_en = 1'b0;
        w_busy  = 1'b1;
        w_done  = 1'b0;
        case (r_state)
            IDLE:    w_busy  = 1'b0;
            FETCH:   w_rd_en = w_credit_ok;
            DRAIN:   w_rd_en = 1'b0;
            DONE:    w_done  = 1'b1;
            default: w_busy  = 1'b0;
        endcase
    end

    // Program counter, run length and the one-deep in-flight read marker.
    // Clearing the marker on reset drops a read that returns right after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_start_acc) begin
                r_pc    <= '0;
                r_count <= instruction_count;
            end else if (w_rd_en) begin
                r_pc <= r_pc + IMEM_ADDR_WIDTH'(1);
            end
        end
    end

    // The full guard never fires while the credit check holds.
    assign w_push = r_inflight && (!w_q_full || w_pop);

    inst_queue #(
        .WIDTH (INST_WIDTH),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (bus.imem_rd_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_q_count),
        .o_empty     (w_q_empty),
        .o_full      (w_q_full)
    );

    // Valids come from queue state only, never from ready, and the head stays
    // put until it pops, so valid and data are stable across a stall.
    assign w_head_tgt  = dispatch_target_e'(w_head[INST_WIDTH-1]);
    assign w_pe_valid  = !w_q_empty && (w_head_tgt == TGT_PE);
    assign w_buf_valid = !w_q_empty && (w_head_tgt == TGT_BUF);
    assign w_pop       = (w_pe_valid && bus.pe_inst_ready) ||
                         (w_buf_valid && bus.buf_inst_ready);

    assign bus.imem_rd_en     = w_rd_en;
    assign bus.imem_addr      = r_pc;
    assign bus.pe_inst_valid  = w_pe_valid;
    assign bus.pe_inst        = w_head;
    assign bus.buf_inst_valid = w_buf_valid;
    assign bus.buf_inst       = w_head;
    assign program_counter    = r_pc;
    assign busy               = w_busy;
    assign done               = w_done;

`ifdef INST_DISPATCH_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    logic [31:0] r_pe_stall;
    logic [31:0] r_buf_stall;

    // Saturating stall counters, cleared by reset or an accepted start.
    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_pe_stall  <= '0;
            r_buf_stall <= '0;
        end else begin
            if (w_pe_valid && !bus.pe_inst_ready) begin
                r_pe_stall <= sat_inc(r_pe_stall);
            end
            if (w_buf_valid && !bus.buf_inst_ready) begin
                r_buf_stall <= sat_inc(r_buf_stall);
            end
        end
    end

    assign pe_stall_cycles  = r_pe_stall;
    assign buf_stall_cycles = r_buf_stall;
`endif
endmodule

// File: tb/tb_inst_dispatch.sv
// Scoreboard bench for inst_dispatch: the stimulus side queues the expected
// (channel, word) of every instruction it loads; a negedge monitor pops and
// compares on each accepted handshake and watches the channel rules.
module tb_inst_dispatch;
    localparam int IW = 32;
    localparam int AW = 8;
    localparam int QD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start;
    logic [AW-1:0] instruction_count;
    logic [AW-1:0] program_counter;
    logic          busy;
    logic          done;
`ifdef INST_DISPATCH_PERF_EN
    logic [31:0]   pe_stall_cycles;
    logic [31:0]   buf_stall_cycles;
`endif

    inst_dispatch_if #(.INST_WIDTH(IW), .ADDR_W(AW)) bus ();

    inst_dispatch #(
        .INST_WIDTH      (IW),
        .IMEM_ADDR_WIDTH (AW),
        .QUEUE_DEPTH     (QD)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .instruction_count (instruction_count),
        .bus               (bus),
        .program_counter   (program_counter),
        .busy              (busy),
        .done              (done)
`ifdef INST_DISPATCH_PERF_EN
        ,
        .pe_stall_cycles   (pe_stall_cycles),
        .buf_stall_cycles  (buf_stall_cycles)
`endif
    );

    // Synchronous-read instruction memory model.
    logic [IW-1:0] imem [0:255];
    always @(posedge clk) begin
        if (bus.imem_rd_en) bus.imem_rd_data <= imem[bus.imem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          tgt;
        logic [IW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int t0       = 0;
    int run_id   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor-owned statistics, restarted whenever run_id changes.
    int   seen_run   = 0;
    int   first_pop  = -1;
    int   last_pop   = -1;
    int   pops_run   = 0;
    int   valid_seen = 0;
    int   rd_run     = 0;
    int   issued     = 0;
    int   popped     = 0;
    logic prev_pe_stall  = 1'b0;
    logic prev_buf_stall = 1'b0;
    logic [IW-1:0] prev_pe_data;
    logic [IW-1:0] prev_buf_data;

    task automatic sb_pop(input logic tgt, input logic [IW-1:0] d, input int rel);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_dispatch: got word 0x%0h on channel %0d, expected nothing", d, tgt);
        end else begin
            e = exp_q.pop_front();
            check("dispatch_channel", {63'd0, tgt}, {63'd0, e.tgt});
            check("dispatch_word", {32'd0, d}, {32'd0, e.data});
        end
        popped++;
        pops_run++;
        if (first_pop < 0) first_pop = rel;
        last_pop = rel;
    endtask

    always @(negedge clk) begin
        int rel;
        if (seen_run != run_id) begin
            seen_run   = run_id;
            first_pop  = -1;
            last_pop   = -1;
            pops_run   = 0;
            valid_seen = 0;
            rd_run     = 0;
        end
        rel = cyc - t0 + 1;
        if (rst) begin
            issued         = 0;
            popped         = 0;
            prev_pe_stall  = 1'b0;
            prev_buf_stall = 1'b0;
        end else begin
            if (prev_pe_stall) begin
                check("pe_hold_valid", {63'd0, bus.pe_inst_valid}, 64'd1);
                check("pe_hold_data", {32'd0, bus.pe_inst}, {32'd0, prev_pe_data});
            end
            if (prev_buf_stall) begin
                check("buf_hold_valid", {63'd0, bus.buf_inst_valid}, 64'd1);
                check("buf_hold_data", {32'd0, bus.buf_inst}, {32'd0, prev_buf_data});
            end
            if (bus.pe_inst_valid || bus.buf_inst_valid) begin
                valid_seen++;
                check("valid_exclusive", {63'd0, bus.pe_inst_valid & bus.buf_inst_valid}, 64'd0);
            end
            if (bus.imem_rd_en) begin
                checks++;
                if (issued - popped >= QD) begin
                    failures++;
                    $display("FAIL credit: outstanding %0d at issue, expected below %0d", issued - popped, QD);
                end
            end
            if (bus.pe_inst_valid && bus.pe_inst_ready) sb_pop(1'b0, bus.pe_inst, rel);
            if (bus.buf_inst_valid && bus.buf_inst_ready) sb_pop(1'b1, bus.buf_inst, rel);
            if (bus.imem_rd_en) begin
                issued++;
                rd_run++;
            end
            prev_pe_stall  = bus.pe_inst_valid && !bus.pe_inst_ready;
            prev_buf_stall = bus.buf_inst_valid && !bus.buf_inst_ready;
            prev_pe_data   = bus.pe_inst;
            prev_buf_data  = bus.buf_inst;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int a, input logic [IW-1:0] w);
        exp_t e;
        imem[a] = w;
        e.tgt   = w[IW-1];
        e.data  = w;
        exp_q.push_back(e);
    endtask

    // Leaves the bench one step into cycle 1 (start sampled at edge E0).
    task automatic do_start(input int cnt);
        instruction_count = AW'(cnt);
        start = 1'b1;
        run_id++;
        tick();
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                at = cyc - t0 + 1;
                break;
            end
        end
        if (at < 0) $display("FAIL wait_done: no done pulse within 200 cycles");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"}, {63'd0, bus.imem_rd_en}, 64'd0);
        check({tag, "_addr"}, {56'd0, bus.imem_addr}, 64'd0);
        check({tag, "_pc"}, {56'd0, program_counter}, 64'd0);
        check({tag, "_pe_valid"}, {63'd0, bus.pe_inst_valid}, 64'd0);
        check({tag, "_buf_valid"}, {63'd0, bus.buf_inst_valid}, 64'd0);
        check({tag, "_pe_inst"}, {32'd0, bus.pe_inst}, 64'd0);
        check({tag, "_buf_inst"}, {32'd0, bus.buf_inst}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int at;
        logic [IW-1:0] w;
        rst = 1'b1;
        start = 1'b0;
        instruction_count = '0;
        bus.pe_inst_ready = 1'b0;
        bus.buf_inst_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_reset_outputs("reset");
`ifdef INST_DISPATCH_PERF_EN
        check("reset_pe_stall", {32'd0, pe_stall_cycles}, 64'd0);
        check("reset_buf_stall", {32'd0, buf_stall_cycles}, 64'd0);
`endif

        // Four PE words, ready held high.
        for (int i = 0; i < 4; i++) put(i, IW'(i + 1));
        bus.pe_inst_ready = 1'b1;
        bus.buf_inst_ready = 1'b1;
        do_start(4);
        check("t1_busy", {63'd0, busy}, 64'd1);
        wait_done(at);
        check("t1_done_cycle", at, 7);
        check("t1_first_valid_cycle", first_pop, 3);
        check("t1_last_valid_cycle", last_pop, 6);
        check("t1_pops", pops_run, 4);
        check("t1_pc", {56'd0, program_counter}, 64'd4);
        check("t1_sb_empty", exp_q.size(), 0);
        tick();
        check("t1_idle_busy", {63'd0, busy}, 64'd0);
        check("t1_idle_done", {63'd0, done}, 64'd0);

        // Alternating buffer / PE words, both ready.
        for (int i = 0; i < 6; i++) put(i, (i % 2 == 0) ? 32'h8000_00A0 : 32'h0000_00B0);
        do_start(6);
        wait_done(at);
        check("t2_done_cycle", at, 9);
        check("t2_pops", pops_run, 6);
        check("t2_back_to_back", last_pop - first_pop, 5);
        check("t2_pc", {56'd0, program_counter}, 64'd6);
        check("t2_sb_empty", exp_q.size(), 0);
        tick();

        // Eight PE words with the PE channel stalled at first.
        for (int i = 0; i < 8; i++) put(i, 32'h0000_0010 + IW'(i));
        bus.pe_inst_ready = 1'b0;
        do_start(8);
        repeat (10) tick();
        bus.pe_inst_ready = 1'b1;
        wait_done(at);
        check("t3_first_pop_cycle", first_pop, 11);
        check("t3_last_pop_cycle", last_pop, 18);
        check("t3_pops", pops_run, 8);
        check("t3_done_cycle", at, 19);
        check("t3_sb_empty", exp_q.size(), 0);
        tick();

        // Zero-length program.
        do_start(0);
        wait_done(at);
        check("t4_done_cycle", at, 1);
        repeat (3) tick();
        check("t4_no_reads", rd_run, 0);
        check("t4_no_valids", valid_seen, 0);
        check("t4_pc", {56'd0, program_counter}, 64'd0);

        // Reset two cycles into a six-word run, then a clean rerun.
        for (int i = 0; i < 6; i++) begin
            w = 32'h0000_0020 + IW'(i);
            if (i == 1 || i == 4) w[IW-1] = 1'b1;
            put(i, w);
        end
        do_start(6);
        tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        exp_q.delete();
        run_id++;
        repeat (5) tick();
        check("t5_late_data_dropped", valid_seen, 0);
        check("t5_idle_busy", {63'd0, busy}, 64'd0);
        for (int i = 0; i < 6; i++) put(i, imem[i]);
        do_start(6);
        wait_done(at);
        check("t5_done_cycle", at, 9);
        check("t5_pops", pops_run, 6);
        check("t5_pc", {56'd0, program_counter}, 64'd6);
        check("t5_sb_empty", exp_q.size(), 0);
        tick();

`ifdef INST_DISPATCH_PERF_EN
        // Buffer-bound head held off for five cycles.
        put(0, 32'h8000_0001);
        bus.buf_inst_ready = 1'b0;
        do_start(1);
        for (int i = 0; i < 20 && !bus.buf_inst_valid; i++) tick();
        repeat (5) tick();
        bus.buf_inst_ready = 1'b1;
        wait_done(at);
        check("t6_buf_stall", {32'd0, buf_stall_cycles}, 64'd5);
        check("t6_pe_stall", {32'd0, pe_stall_cycles}, 64'd0);
        check("t6_sb_empty", exp_q.size(), 0);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
